// File: rtl/bloqueio_pkg.sv
// Shared constants, state encoding and helpers for the password lockout front end.
package bloqueio_pkg;

  typedef enum logic {
    OCIOSO   = 1'b0,
    BLOQUEIO = 1'b1
  } estado_t;

  localparam int unsigned SENHA_W            = 4;
  localparam int unsigned ERR_W              = 2;
  localparam logic [SENHA_W-1:0] SENHA_CORRETA_DEF = 4'b1010;
  localparam int unsigned MAX_ERROS_DEF      = 3;
  localparam int unsigned T_BLOQUEIO_DEF     = 200;
  localparam int unsigned TW_DEF             = 8;

  // Progressive lockout shift: lockout count clamped to 2.
  function automatic logic [1:0] lock_shift(input logic [1:0] n);
    return (n > 2'd2) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/contador_bloqueio.sv
// Loadable lockout down-counter with registered terminal count (count == 1).
// With BLOQUEIO_PROGRESSIVO_EN the load value is shifted by the clamped lockout count.
module contador_bloqueio
  import bloqueio_pkg::*;
#(
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [TW-1:0] load_val_i,
`ifdef BLOQUEIO_PROGRESSIVO_EN
  input  logic [1:0]    shift_i,
`endif
  output logic          tc_o
);

`ifdef BLOQUEIO_PROGRESSIVO_EN
  localparam int unsigned CW = TW + 2;
`else
  localparam int unsigned CW = TW;
`endif

  logic [CW-1:0] count_q, count_d, load_v;
  logic          tc_q;

`ifdef BLOQUEIO_PROGRESSIVO_EN
  assign load_v = CW'(load_val_i) << lock_shift(shift_i);
`else
  assign load_v = load_val_i;
`endif

  // Next count: load wins over decrement; stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_v;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= (count_d == CW'(1));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/bloqueio_senha.sv
// Password entry with consecutive-error counting and timed lockout.
// Optional macro BLOQUEIO_PROGRESSIVO_EN doubles lockout length on repeated lockouts.
module bloqueio_senha
  import bloqueio_pkg::*;
#(
  parameter logic [SENHA_W-1:0] SENHA_CORRETA = SENHA_CORRETA_DEF,
  parameter int unsigned        MAX_ERROS     = MAX_ERROS_DEF,
  parameter int unsigned        T_BLOQUEIO    = T_BLOQUEIO_DEF,
  parameter int unsigned        TW            = TW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               B,
  input  logic [SENHA_W-1:0] SENHA,
  input  logic               estado_fe,
  input  logic               H,
  output logic               senha_ok,
  output logic [ERR_W-1:0]   error_count,
  output logic               bloqueado,
  output logic               alarme
);

  localparam int unsigned      EW1     = ERR_W + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(MAX_ERROS);
  localparam logic [TW-1:0]    T_LOAD  = TW'(T_BLOQUEIO);

  estado_t          state_q;
  logic             b_prev_q;
  logic [ERR_W-1:0] err_q;
  logic             ok_q, al_q, bloq_q;

  logic clr, press, accept, correct, last_try, cnt_load, cnt_en, tc;

  assign clr      = reset | H;
  assign press    = B & ~b_prev_q;
  assign accept   = press & estado_fe & (state_q == OCIOSO);
  assign correct  = (SENHA == SENHA_CORRETA);
  assign last_try = (EW1'(err_q) + EW1'(1)) >= EW1'(MAX_ERROS);
  assign cnt_load = accept & ~correct & last_try;
  assign cnt_en   = (state_q == BLOQUEIO);

`ifdef BLOQUEIO_PROGRESSIVO_EN
  logic [1:0] lock_n_q;

  // Lockouts since the last correct attempt; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (clr || (accept && correct)) begin
      lock_n_q <= 2'd0;
    end else if (cnt_load && (lock_n_q != 2'd3)) begin
      lock_n_q <= lock_n_q + 2'd1;
    end
  end
`endif

  contador_bloqueio #(
    .TW (TW)
  ) u_contador (
    .clk        (clk),
    .clr_i      (clr),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (T_LOAD),
`ifdef BLOQUEIO_PROGRESSIVO_EN
    .shift_i    (lock_n_q),
`endif
    .tc_o       (tc)
  );

  // Attempt/lockout state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= OCIOSO;
      b_prev_q <= 1'b0;
      err_q    <= '0;
      ok_q     <= 1'b0;
      al_q     <= 1'b0;
      bloq_q   <= 1'b0;
    end else begin
      b_prev_q <= B;
      ok_q     <= 1'b0;
      al_q     <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (accept) begin
            if (correct) begin
              ok_q  <= 1'b1;
              err_q <= '0;
            end else if (!last_try) begin
              err_q <= err_q + ERR_W'(1);
            end else begin
              err_q   <= ERR_MAX;
              al_q    <= 1'b1;
              bloq_q  <= 1'b1;
              state_q <= BLOQUEIO;
            end
          end
        end
        BLOQUEIO: begin
          if (tc) begin
            state_q <= OCIOSO;
            bloq_q  <= 1'b0;
            err_q   <= '0;
          end
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign senha_ok    = ok_q;
  assign error_count = err_q;
  assign bloqueado   = bloq_q;
  assign alarme      = al_q;

endmodule
